// File: rtl/snake_pkg.sv
// Shared snake-game types: 2-bit direction encoding, game_status values and
// the direction-reversal helper used by the turn legality filter.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_RESTART = 2'd0,
    ST_START   = 2'd1,
    ST_PLAY    = 2'd2,
    ST_DIE     = 2'd3
  } status_e;

  // Opposite pairs differ only in the LSB (UP/DOWN, LEFT/RIGHT).
  function automatic dir_t dir_opposite(input dir_t d);
    return d ^ 2'd1;
  endfunction

endpackage

// File: rtl/turn_queue_dir_fifo.sv
// DEPTH-entry FIFO of 2-bit directions with flush and simultaneous push/pop;
// exposes head, tail (most recent push) and occupancy count.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  dir_t       i_data,
  output dir_t       o_head,
  output dir_t       o_tail,
  output logic       o_full,
  output logic       o_empty,
  output logic [2:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [2:0]    r_count;
  dir_t          r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == 3'd0);
  assign o_full  = (r_count == 3'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_tail  = r_mem[r_wr_ptr - PW'(1)];
  assign o_count = r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
    end
  end

  // NOTE: storage is deliberately not reset; r_count gates every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/turn_queue.sv
// Direction-command buffer: queues legal turns and applies one per move tick.
// Optional TURN_QUEUE_DROP_CNT_EN adds a saturating drop_cnt debug counter.
module turn_queue
  import snake_pkg::*;
#(
  parameter int   DEPTH    = 2,
  parameter dir_t INIT_DIR = DIR_RIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_press,
  input  logic       down_press,
  input  logic       left_press,
  input  logic       right_press,
  input  logic [1:0] game_status,
  input  logic       move_tick,
  output logic [1:0] cur_dir,
  output logic [2:0] q_count,
  output logic       drop
`ifdef TURN_QUEUE_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  dir_t r_cur_dir;
  logic r_drop;

  dir_t       w_cand;
  logic       w_has_cand;
  dir_t       w_ref;
  logic       w_legal;
  logic       w_play;
  logic       w_restart;
  logic       w_push;
  logic       w_pop;
  dir_t       w_head;
  dir_t       w_tail;
  logic       w_full;
  logic       w_empty;
  logic [2:0] w_count;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_cand     = DIR_UP;
    w_has_cand = 1'b1;
    if (up_press)          w_cand = DIR_UP;
    else if (down_press)   w_cand = DIR_DOWN;
    else if (left_press)   w_cand = DIR_LEFT;
    else if (right_press)  w_cand = DIR_RIGHT;
    else                   w_has_cand = 1'b0;
  end

  assign w_play    = (game_status == ST_PLAY);
  assign w_restart = (game_status == ST_RESTART);
  assign w_ref     = w_empty ? r_cur_dir : w_tail;
  assign w_legal   = w_has_cand && (w_cand != w_ref) && (w_cand != dir_opposite(w_ref));

  // On a tick a pop frees a slot, so a full queue still accepts the new turn.
  assign w_pop  = w_play && move_tick && !w_empty;
  assign w_push = w_play && w_legal && (move_tick ? !w_empty : !w_full);

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (w_restart),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cand),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_dir <= INIT_DIR;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= w_play && w_legal && !move_tick && w_full;
      if (w_restart)                                r_cur_dir <= INIT_DIR;
      else if (w_pop)                               r_cur_dir <= w_head;
      else if (w_play && move_tick && w_legal)      r_cur_dir <= w_cand;
    end
  end

`ifdef TURN_QUEUE_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_drop_cnt <= 8'd0;
    else if (w_restart)                        r_drop_cnt <= 8'd0;
    else if (w_play && w_legal && !move_tick && w_full && r_drop_cnt != 8'hFF)
                                               r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign cur_dir = r_cur_dir;
  assign q_count = w_count;
  assign drop    = r_drop;

endmodule

// File: tb/tb_turn_queue.sv
// Self-checking bench for turn_queue: directed scenarios plus random stimulus
// compared every cycle against a queue-based behavioural model.
module tb_turn_queue;
  import snake_pkg::*;

  localparam int DEPTH = 2;
  localparam int INIT  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_press, down_press, left_press, right_press;
  logic [1:0] game_status;
  logic       move_tick;
  logic [1:0] cur_dir;
  logic [2:0] q_count;
  logic       drop;
`ifdef TURN_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  turn_queue #(.DEPTH(DEPTH), .INIT_DIR(2'd3)) dut (
    .clk         (clk),
    .rst         (rst),
    .up_press    (up_press),
    .down_press  (down_press),
    .left_press  (left_press),
    .right_press (right_press),
    .game_status (game_status),
    .move_tick   (move_tick),
    .cur_dir     (cur_dir),
    .q_count     (q_count),
    .drop        (drop)
`ifdef TURN_QUEUE_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q[$];
  int m_cur;
  int m_drop;
  int m_dcnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur  = INIT;
    m_drop = 0;
    m_dcnt = 0;
  endtask

  task automatic model_step(input bit u, input bit d, input bit l, input bit r,
                            input logic [1:0] gs, input bit t);
    int  cand;
    int  rf;
    bit  legal;
    m_drop = 0;
    if (gs == ST_RESTART) begin
      m_q.delete();
      m_cur  = INIT;
      m_dcnt = 0;
    end else if (gs == ST_PLAY) begin
      cand = u ? 0 : d ? 1 : l ? 2 : 3;
      rf   = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_cur;
      legal = (u || d || l || r) && cand != rf && cand != (rf ^ 1);
      if (t) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          if (legal) m_q.push_back(cand);
        end else if (legal) begin
          m_cur = cand;
        end
      end else if (legal) begin
        if (m_q.size() < DEPTH) m_q.push_back(cand);
        else begin
          m_drop = 1;
          if (m_dcnt < 255) m_dcnt++;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cur_dir"}, 32'(cur_dir), 32'(m_cur));
    check({tag, ".q_count"}, 32'(q_count), 32'(m_q.size()));
    check({tag, ".drop"},    32'(drop),    32'(m_drop));
`ifdef TURN_QUEUE_DROP_CNT_EN
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_dcnt));
`endif
  endtask

  task automatic step(input bit u, input bit d, input bit l, input bit r,
                      input logic [1:0] gs, input bit t, input string tag);
    up_press = u; down_press = d; left_press = l; right_press = r;
    game_status = gs; move_tick = t;
    @(posedge clk);
    model_step(u, d, l, r, gs, t);
    #1;
    compare_all(tag);
    up_press = 0; down_press = 0; left_press = 0; right_press = 0; move_tick = 0;
  endtask

  task automatic idle(input int n, input logic [1:0] gs);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, gs, 0, "idle");
  endtask

  initial begin
    rst = 1'b0;
    up_press = 0; down_press = 0; left_press = 0; right_press = 0;
    move_tick = 0; game_status = ST_PLAY;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk) rst = 1'b1;

    // No presses, three ticks: direction stays RIGHT
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, ST_PLAY, 1, "notick_press");
    check("t1.cur_dir", 32'(cur_dir), 32'd3);

    // Up then left, five cycles apart, then two ticks
    step(1, 0, 0, 0, ST_PLAY, 0, "t2.up");
    check("t2.q1", 32'(q_count), 32'd1);
    idle(4, ST_PLAY);
    step(0, 0, 1, 0, ST_PLAY, 0, "t2.left");
    check("t2.q2", 32'(q_count), 32'd2);
    step(0, 0, 0, 0, ST_PLAY, 1, "t2.tick1");
    check("t2.dir_up", 32'(cur_dir), 32'd0);
    step(0, 0, 0, 0, ST_PLAY, 1, "t2.tick2");
    check("t2.dir_left", 32'(cur_dir), 32'd2);
    check("t2.q0", 32'(q_count), 32'd0);

    // Reversal and repeat are discarded silently
    step(0, 0, 0, 0, ST_RESTART, 0, "t3.restart");
    step(0, 0, 1, 0, ST_PLAY, 0, "t3.left");
    step(0, 0, 0, 1, ST_PLAY, 0, "t3.right");
    check("t3.q0", 32'(q_count), 32'd0);
    check("t3.nodrop", 32'(drop), 32'd0);

    // Full queue {UP,LEFT}: down drops; down with tick does not
    step(1, 0, 0, 0, ST_PLAY, 0, "t4.up");
    step(0, 0, 1, 0, ST_PLAY, 0, "t4.left");
    step(0, 1, 0, 0, ST_PLAY, 0, "t4.down_full");
    check("t4.drop", 32'(drop), 32'd1);
    check("t4.q2", 32'(q_count), 32'd2);
    step(0, 0, 0, 0, ST_PLAY, 0, "t4.after");
    check("t4.drop_clr", 32'(drop), 32'd0);
    step(0, 1, 0, 0, ST_PLAY, 1, "t4.down_tick");
    check("t4.nodrop", 32'(drop), 32'd0);
    check("t4.dir_up", 32'(cur_dir), 32'd0);
    check("t4.q_keep", 32'(q_count), 32'd2);
    step(0, 0, 0, 0, ST_PLAY, 1, "t4.pop_left");
    check("t4.dir_left", 32'(cur_dir), 32'd2);
    step(0, 0, 0, 0, ST_PLAY, 1, "t4.pop_down");
    check("t4.dir_down", 32'(cur_dir), 32'd1);

    // Bypass and simultaneous-press priority
    step(0, 0, 0, 0, ST_RESTART, 0, "t5.restart");
    step(1, 0, 0, 0, ST_PLAY, 1, "t5.bypass");
    check("t5.dir_up", 32'(cur_dir), 32'd0);
    check("t5.q0", 32'(q_count), 32'd0);
    step(0, 0, 0, 0, ST_RESTART, 0, "t5.restart2");
    step(1, 0, 1, 0, ST_PLAY, 0, "t5.multi");
    check("t5.q1", 32'(q_count), 32'd1);
    step(0, 0, 0, 0, ST_PLAY, 1, "t5.tick");
    check("t5.only_up", 32'(cur_dir), 32'd0);

    // RESTART flushes; START/DIE freeze
    step(0, 0, 1, 0, ST_PLAY, 0, "t6.left");
    step(1, 0, 0, 0, ST_PLAY, 0, "t6.up");
    step(0, 0, 0, 0, ST_RESTART, 1, "t6.restart");
    check("t6.q0", 32'(q_count), 32'd0);
    check("t6.dir", 32'(cur_dir), 32'd3);
    step(1, 0, 0, 0, ST_PLAY, 0, "t6.up2");
    step(0, 0, 1, 0, ST_PLAY, 0, "t6.left2");
    step(0, 1, 0, 0, ST_DIE, 1, "t6.die");
    step(0, 1, 0, 0, ST_START, 1, "t6.start");
    check("t6.frozen_q", 32'(q_count), 32'd2);
    check("t6.frozen_dir", 32'(cur_dir), 32'd3);

`ifdef TURN_QUEUE_DROP_CNT_EN
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0, ST_PLAY, 0, "t7.drops");
    check("t7.sat", 32'(drop_cnt), 32'd255);
`endif

    // Asynchronous reset in the middle of a cycle
    step(1, 0, 0, 0, ST_PLAY, 0, "t8.up");
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all("t8.async_rst");
    @(negedge clk) rst = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int         r;
      logic [1:0] gs;
      r  = $urandom_range(0, 29);
      gs = (r == 0) ? ST_RESTART : (r == 1) ? ST_START : (r == 2) ? ST_DIE : ST_PLAY;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           gs, $urandom_range(0, 2) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_queue.md
Name: turn_queue

Overview:
- Direction-command buffer between the `buttons` debouncer and `snake_moving`.
- Captures single-cycle key-press pulses into a small FIFO and drops illegal turns (repeat or 180° reversal).
- Applies exactly one queued turn per snake move tick, so two quick presses between ticks (e.g. up then left) both take effect on successive moves.
- Output `cur_dir` replaces the raw press pulses as the direction source for `snake_moving`.

Parameters:
- DEPTH, 2, FIFO entries; legal values 2 or 4.
- INIT_DIR, 2'd3 (RIGHT), direction loaded at reset and on RESTART.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- up_press  in  1  one-cycle pulse from `buttons`
- down_press  in  1  one-cycle pulse from `buttons`
- left_press  in  1  one-cycle pulse from `buttons`
- right_press  in  1  one-cycle pulse from `buttons`
- game_status  in  2  from `game_status_control`
- move_tick  in  1  one-cycle pulse; `snake_moving` advances the head this cycle
- cur_dir  out  2  direction in force for the next move
- q_count  out  3  entries held, 0..DEPTH
- drop  out  1  one-cycle pulse: press discarded because the queue was full

Behaviour:
- Reset (rst low, asynchronous): `cur_dir`=INIT_DIR, `q_count`=0, `drop`=0, FIFO pointers 0.
- Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3. Opposite of d is d^1.
- Press selection:
  - Several presses in one cycle: one candidate only, priority up > down > left > right.
  - The others are ignored and do not raise `drop`.
- Reference direction `ref` = FIFO tail entry if `q_count`>0, else `cur_dir`.
- Candidate is legal iff cand != ref and cand != (ref^1). Illegal candidates are silently discarded (`drop` stays 0).
- game_status behaviour:
  - RESTART: flush FIFO, `cur_dir`<=INIT_DIR, ignore presses and ticks.
  - START, DIE: hold all state, ignore presses and ticks.
  - PLAY: normal operation, per the rules below.
- PLAY, per cycle, with legal candidate L present or absent and tick T:
  - No L, no T: hold.
  - L, no T, not full: push L; `q_count`+1, registered (visible next cycle).
  - L, no T, full: discard L; `drop`=1 for one cycle.
  - T, no L, non-empty: `cur_dir`<=head, pop.
  - T, no L, empty: hold.
  - L and T, empty (bypass): `cur_dir`<=L; FIFO stays empty.
  - L and T, non-empty: pop head into `cur_dir` and push L in the same cycle; `q_count` unchanged. This applies even when full, with no drop.
- Pointers wrap modulo DEPTH. Outputs are registered, so latency from press to `q_count` change is 1 cycle.
- `cur_dir` changes only on a tick edge, never between ticks.
- Reset asserted mid-operation: immediate return to reset values; in-flight press lost.

Optional Feature:
- Macro TURN_QUEUE_DROP_CNT_EN.
- Defined: adds output port `drop_cnt` [7:0]. It increments on each `drop` pulse, saturates at 255, clears on reset and in RESTART. Feeds the debug LEDs.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package `snake_pkg`:
  - direction constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT, 2-bit direction typedef;
  - game_status constants ST_RESTART/ST_START/ST_PLAY/ST_DIE;
  - helper function `dir_opposite`.
- One sub-module, `dir_fifo`: parameterised DEPTH-entry 2-bit FIFO with push/pop/full/empty/tail/count and simultaneous push-pop support.
- Press priority, legality filter, bypass and game_status gating stay in `turn_queue`.

Test Plan:
- Reset, PLAY, no presses, 3 ticks -> `cur_dir`=3 throughout, `q_count`=0.
- PLAY, `cur_dir`=RIGHT, press up then left 5 cycles apart, then 2 ticks -> `q_count` 1 then 2; after tick1 `cur_dir`=0, after tick2 `cur_dir`=2, `q_count`=0.
- PLAY, `cur_dir`=RIGHT, press left, then press right -> both discarded, `q_count`=0, `drop` never 1.
- DEPTH=2, queue holds {UP,LEFT}, press down -> `drop`=1 for exactly one cycle, `q_count`=2. Press down coincident with tick -> no drop, `cur_dir`=0, queue {LEFT,DOWN}.
- Empty queue, `cur_dir`=RIGHT, up_press and move_tick same cycle -> `cur_dir`=0 next cycle, `q_count`=0. Simultaneous up+left press -> only UP enqueued.
- Queue holds 2 entries, game_status=RESTART -> `q_count`=0, `cur_dir`=3. In DIE, presses and ticks leave state unchanged. With TURN_QUEUE_DROP_CNT_EN, 300 drops -> `drop_cnt`=255.
